// File: rtl/enable_strobe_serializer.sv
// enable_strobe_serializer
// Accepts an N-bit word over a valid/ready handshake and replays it LSB first
// on ser_d, one bit every DIV clocks, each bit qualified by a one-cycle
// ser_enable strobe. ser_last marks the final strobe of a word.
//
// Optional build macro: SER_PARITY_EN
//   defined   -> an extra (N+1)-th strobe carries the even parity of the word
//   undefined -> exactly N strobes, no parity storage
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a word; load_ready high
// SHIFT | replaying the stored word, one strobe per DIV clocks
module enable_strobe_serializer #(
   parameter int N   = 8,
   parameter int DIV = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [N-1:0] load_data,
   output logic         ser_enable,
   output logic         ser_d,
   output logic         ser_last,
   output logic         busy
);

`ifdef SER_PARITY_EN
   localparam int L = N + 1;
`else
   localparam int L = N;
`endif
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = $clog2(L + 1);

   localparam logic [DW-1:0] DIV_TC = DW'(DIV - 1);
   localparam logic [BW-1:0] BIT_TC = BW'(L - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t          state;
   logic [L-1:0]    shreg;
   logic [DW-1:0]   div_cnt;
   logic [BW-1:0]   bit_cnt;

   // Handshake, bit pacing and registered serial outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         shreg      <= '0;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         ser_enable <= 1'b0;
         ser_d      <= 1'b0;
         ser_last   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ser_enable <= 1'b0;
               ser_last   <= 1'b0;
               if (load_valid) begin
`ifdef SER_PARITY_EN
                  // Parity rides as the top bit so it falls out of the shift last.
                  shreg <= {^load_data, load_data};
`else
                  shreg <= load_data;
`endif
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (div_cnt == DIV_TC) begin
                  div_cnt    <= '0;
                  ser_enable <= 1'b1;
                  ser_d      <= shreg[0];
                  shreg      <= shreg >> 1;
                  ser_last   <= (bit_cnt == BIT_TC);
                  bit_cnt    <= bit_cnt + 1'b1;
                  // Returning to IDLE on the final strobe lets the next word
                  // be accepted while that strobe is still visible.
                  if (bit_cnt == BIT_TC)
                     state <= IDLE;
               end else begin
                  div_cnt    <= div_cnt + 1'b1;
                  ser_enable <= 1'b0;
                  ser_last   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign load_ready = (state == IDLE);
   assign busy       = (state == SHIFT);

endmodule

// File: tb/tb_enable_strobe_serializer.sv
// Bench for enable_strobe_serializer: two instances (DIV=4 and DIV=1) share
// one stimulus stream; a timeline model predicts every strobe from the
// accept edge, and all outputs are compared after each clock edge.
module tb_enable_strobe_serializer;

   localparam int N = 8;
`ifdef SER_PARITY_EN
   localparam int L = N + 1;
`else
   localparam int L = N;
`endif
   localparam int DIVS [2] = '{4, 1};

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         load_valid = 1'b0;
   logic [N-1:0] load_data = '0;
   logic [1:0]   rdy, en, sd, last, bsy;

   always #5 clock = ~clock;

   enable_strobe_serializer #(.N(N), .DIV(4)) u_div4 (
      .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(rdy[0]),
      .load_data(load_data), .ser_enable(en[0]), .ser_d(sd[0]), .ser_last(last[0]),
      .busy(bsy[0]));

   enable_strobe_serializer #(.N(N), .DIV(1)) u_div1 (
      .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(rdy[1]),
      .load_data(load_data), .ser_enable(en[1]), .ser_d(sd[1]), .ser_last(last[1]),
      .busy(bsy[1]));

   typedef struct {
      int inst;
      int t;
      bit d;
      bit last;
   } ev_t;

   ev_t evq[$];
   int  free_at [2];
   bit  cur_d [2];
   int  cyc = 0;
   int  n_chk = 0;
   int  n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
   endtask

   // Timeline model: a word accepted at edge t puts bit k on edge t+(k+1)*DIV,
   // and the block is free again from edge t+L*DIV+1.
   task automatic model_edge(input bit r, input bit v, input logic [N-1:0] d);
      logic [L-1:0] word;
      if (r) begin
         evq.delete();
         for (int i = 0; i < 2; i++) begin
            free_at[i] = cyc + 1;
            cur_d[i]   = 1'b0;
         end
         return;
      end
`ifdef SER_PARITY_EN
      word = {^d, d};
`else
      word = d;
`endif
      for (int i = 0; i < 2; i++) begin
         if (v && cyc >= free_at[i]) begin
            for (int k = 0; k < L; k++)
               evq.push_back('{inst: i, t: cyc + (k + 1) * DIVS[i], d: word[k], last: (k == L - 1)});
            free_at[i] = cyc + L * DIVS[i] + 1;
         end
      end
   endtask

   task automatic check_outputs(input bit r);
      bit exp_en, exp_last;
      for (int i = 0; i < 2; i++) begin
         exp_en   = 1'b0;
         exp_last = 1'b0;
         for (int j = 0; j < evq.size(); j++) begin
            if (evq[j].inst == i && evq[j].t == cyc) begin
               exp_en   = 1'b1;
               exp_last = evq[j].last;
               cur_d[i] = evq[j].d;
            end
         end
         check($sformatf("ser_enable[%0d]", i), 32'(en[i]), 32'(exp_en));
         check($sformatf("ser_d[%0d]", i), 32'(sd[i]), 32'(cur_d[i]));
         check($sformatf("ser_last[%0d]", i), 32'(last[i]), 32'(exp_last));
         check($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(cyc + 1 < free_at[i]));
         check($sformatf("load_ready[%0d]", i), 32'(rdy[i]), 32'(cyc + 1 >= free_at[i]));
         if (r) begin
            check($sformatf("rst_ready[%0d]", i), 32'(rdy[i]), 32'd1);
            check($sformatf("rst_enable[%0d]", i), 32'(en[i]), 32'd0);
         end
      end
      for (int j = evq.size() - 1; j >= 0; j--)
         if (evq[j].t <= cyc) evq.delete(j);
   endtask

   task automatic tick();
      bit r;
      r = reset;
      @(posedge clock);
      model_edge(reset, load_valid, load_data);
      #1;
      check_outputs(r);
      cyc++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      free_at = '{0, 0};
      cur_d   = '{1'b0, 1'b0};

      // Reset, then a quiet idle stretch.
      reset = 1'b1;
      ticks(2);
      reset = 1'b0;
      ticks(20);

      // Single word 8'hA5.
      load_valid = 1'b1; load_data = 8'hA5;
      tick();
      load_valid = 1'b0; load_data = 8'h00;
      ticks(40);

      // Back-to-back words with valid held: FF then a run of 00.
      load_valid = 1'b1; load_data = 8'hFF;
      tick();
      load_data = 8'h00;
      ticks(30);
      load_valid = 1'b0;
      ticks(40);

      // Word 3C presented while busy with A5.
      load_valid = 1'b1; load_data = 8'hA5;
      tick();
      load_valid = 1'b0;
      ticks(5);
      load_valid = 1'b1; load_data = 8'h3C;
      ticks(30);
      load_valid = 1'b0;
      ticks(40);

      // Reset on the cycle the 3rd strobe of A5 (DIV=4 instance) is visible.
      load_valid = 1'b1; load_data = 8'hA5;
      tick();
      load_valid = 1'b0;
      ticks(12);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      ticks(3);
      load_valid = 1'b1; load_data = 8'h01;
      tick();
      load_valid = 1'b0;
      ticks(40);

      // Parity-carrying pattern 8'h07.
      load_valid = 1'b1; load_data = 8'h07;
      tick();
      load_valid = 1'b0;
      ticks(45);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 900; i++) begin
         load_valid = ($urandom_range(0, 2) == 0);
         load_data  = N'($urandom);
         reset      = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 1'b0;
      load_valid = 1'b0;
      ticks(45);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
